// File: rtl/pred_stabilizer_if.sv
// rtl/pred_stabilizer_if.sv - argmax result in / committed prediction out bundle (PRED_ASCII_EN adds pred_ascii_o)
interface pred_stabilizer_if;
  logic       cls_valid_i;
  logic [4:0] cls_idx_i;
  logic [7:0] cls_conf_i;
  logic       pred_valid_o;
  logic [4:0] pred_idx_o;
  logic [7:0] pred_conf_o;
  logic       pred_change_o;
  logic [1:0] state_o;
`ifdef PRED_ASCII_EN
  logic [7:0] pred_ascii_o;
`endif

  modport master (
    output cls_valid_i, cls_idx_i, cls_conf_i,
    input  pred_valid_o, pred_idx_o, pred_conf_o, pred_change_o, state_o
`ifdef PRED_ASCII_EN
    , pred_ascii_o
`endif
  );

  modport slave (
    input  cls_valid_i, cls_idx_i, cls_conf_i,
    output pred_valid_o, pred_idx_o, pred_conf_o, pred_change_o, state_o
`ifdef PRED_ASCII_EN
    , pred_ascii_o
`endif
  );
endinterface

// File: rtl/pred_stabilizer.sv
// rtl/pred_stabilizer.sv - temporal filter committing an argmax class after HOLD_FRAMES qualified wins (PRED_ASCII_EN adds pred_ascii_o)
module pred_stabilizer #(
  parameter int         NUM_CLASSES = 29,
  parameter logic [7:0] CONF_MIN    = 8'd128,
  parameter int         HOLD_FRAMES = 4,
  parameter int         MISS_FRAMES = 3,
  parameter int         TIMEOUT_CYC = 5_000_000
) (
  input  logic             clk,
  input  logic             reset,
  pred_stabilizer_if.slave bus
);

  localparam int RUN_W  = $clog2(HOLD_FRAMES + 1);
  localparam int MISS_W = $clog2(MISS_FRAMES + 1);
  localparam int TMO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [RUN_W-1:0]  HOLD_R  = RUN_W'(HOLD_FRAMES);
  localparam logic [MISS_W-1:0] MISS_R  = MISS_W'(MISS_FRAMES);
  localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT_CYC);
  localparam logic              HOLD_ONE = (HOLD_FRAMES == 1);
  localparam logic              TMO_EN   = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state;
  logic [4:0]        cand;
  logic [RUN_W-1:0]  run;
  logic [MISS_W-1:0] miss;
  logic [TMO_W-1:0]  tmo;
  logic              pred_valid;
  logic [4:0]        pred_idx;
  logic [7:0]        pred_conf;
  logic              pred_change;

  logic              frame, qual, rej, same_cand, same_pred;
  logic [RUN_W-1:0]  run_inc;
  logic [MISS_W-1:0] miss_inc;
  logic [TMO_W-1:0]  tmo_inc;
  logic              commit, miss_hit, tmo_hit, clear;

  assign frame     = bus.cls_valid_i;
  assign qual      = frame && (bus.cls_conf_i >= CONF_MIN) && (int'(bus.cls_idx_i) < NUM_CLASSES);
  assign rej       = frame && !qual;
  assign same_cand = (bus.cls_idx_i == cand);
  assign same_pred = (bus.cls_idx_i == pred_idx);

  assign run_inc  = (run == HOLD_R)   ? run  : run + RUN_W'(1);
  assign miss_inc = (miss == MISS_R)  ? miss : miss + MISS_W'(1);
  assign tmo_inc  = (tmo == TMO_MAX)  ? tmo  : tmo + TMO_W'(1);

  // Every commit takes the incoming index: in TRACK it equals cand by construction.
  assign commit = qual && ((state == IDLE   && HOLD_ONE) ||
                           (state == TRACK  && same_cand && run_inc == HOLD_R) ||
                           (state == LOCKED && !same_pred && HOLD_ONE));

  assign miss_hit = rej && (miss_inc == MISS_R);
  assign tmo_hit  = TMO_EN && !frame && (tmo_inc == TMO_MAX);
  assign clear    = miss_hit || tmo_hit;

`ifdef PRED_ASCII_EN
  logic [7:0] pred_ascii;

  function automatic logic [7:0] idx_to_ascii(input logic [4:0] idx);
    if (idx <= 5'd25)      return 8'h41 + {3'b000, idx};
    else if (idx == 5'd26) return 8'h7F;
    else if (idx == 5'd28) return 8'h20;
    else                   return 8'h00;
  endfunction
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cand        <= '0;
      run         <= '0;
      miss        <= '0;
      tmo         <= '0;
      pred_valid  <= 1'b0;
      pred_idx    <= '0;
      pred_conf   <= '0;
      pred_change <= 1'b0;
`ifdef PRED_ASCII_EN
      pred_ascii  <= '0;
`endif
    end else begin
      pred_change <= 1'b0;
      tmo         <= frame ? '0 : tmo_inc;

      if (commit) begin
        miss        <= '0;
        cand        <= bus.cls_idx_i;
        run         <= '0;
        state       <= LOCKED;
        pred_valid  <= 1'b1;
        pred_idx    <= bus.cls_idx_i;
        pred_conf   <= bus.cls_conf_i;
        pred_change <= !pred_valid || !same_pred;
`ifdef PRED_ASCII_EN
        pred_ascii  <= idx_to_ascii(bus.cls_idx_i);
`endif
      end else if (qual) begin
        miss <= '0;
        case (state)
          IDLE: begin
            cand  <= bus.cls_idx_i;
            run   <= RUN_W'(1);
            state <= TRACK;
          end
          TRACK: begin
            if (same_cand) begin
              run <= run_inc;
            end else if (pred_valid && same_pred) begin
              // Committed class came back before the challenger won: fall back silently.
              run       <= '0;
              state     <= LOCKED;
              pred_conf <= bus.cls_conf_i;
            end else begin
              cand <= bus.cls_idx_i;
              run  <= RUN_W'(1);
            end
          end
          LOCKED: begin
            if (same_pred) begin
              pred_conf <= bus.cls_conf_i;
            end else begin
              cand  <= bus.cls_idx_i;
              run   <= RUN_W'(1);
              state <= TRACK;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (rej) begin
        miss <= miss_inc;
        if (state == TRACK) begin
          state <= IDLE;
          run   <= '0;
        end
      end

      // Miss limit and timeout share one drop path so a coincidence yields one pulse.
      if (clear) begin
        state <= IDLE;
        run   <= '0;
        if (pred_valid) begin
          pred_valid  <= 1'b0;
          pred_change <= 1'b1;
        end
      end
    end
  end

  assign bus.pred_valid_o  = pred_valid;
  assign bus.pred_idx_o    = pred_idx;
  assign bus.pred_conf_o   = pred_conf;
  assign bus.pred_change_o = pred_change;
  assign bus.state_o       = state;
`ifdef PRED_ASCII_EN
  assign bus.pred_ascii_o  = pred_ascii;
`endif

endmodule

// File: tb/tb_pred_stabilizer.sv
// tb/tb_pred_stabilizer.sv - directed and randomized bench for pred_stabilizer against a frame-level reference model
module tb_pred_stabilizer;
  localparam int HOLD = 4;
  localparam int MISS = 3;
  localparam int TMO  = 10;
  localparam int S_IDLE = 0, S_TRACK = 1, S_LOCKED = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pred_stabilizer_if bus ();

  pred_stabilizer #(
    .NUM_CLASSES(29), .CONF_MIN(8'd128), .HOLD_FRAMES(HOLD),
    .MISS_FRAMES(MISS), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  int         m_state, m_cand, m_run, m_miss, m_quiet;
  logic       m_valid, m_change;
  logic [4:0] m_idx;
  logic [7:0] m_conf, m_ascii;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_outs();
    return {15'd0, bus.pred_valid_o, bus.pred_idx_o, bus.pred_conf_o, bus.pred_change_o, bus.state_o};
  endfunction

  function automatic logic [7:0] to_ascii(input logic [4:0] idx);
    string letters;
    letters = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    if (idx < 26) return 8'(letters[idx]);
    if (idx == 26) return 8'h7F;
    if (idx == 28) return 8'h20;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_cand = 0; m_run = 0; m_miss = 0; m_quiet = 0;
    m_valid = 1'b0; m_change = 1'b0; m_idx = '0; m_conf = '0; m_ascii = '0;
  endtask

  task automatic drop();
    m_valid = 1'b0;
    m_state = S_IDLE;
    m_run   = 0;
  endtask

  task automatic model_step(input logic v, input logic [4:0] idx, input logic [7:0] conf);
    logic       pv;
    logic [4:0] pi;
    pv = m_valid;
    pi = m_idx;
    if (!v) begin
      m_quiet++;
      if (m_quiet >= TMO) drop();
    end else begin
      m_quiet = 0;
      if (conf >= 8'd128 && idx < 29) begin
        m_miss = 0;
        if (m_state == S_LOCKED && idx == m_idx) begin
          m_conf = conf;
        end else if (m_state == S_TRACK && int'(idx) != m_cand && m_valid && idx == m_idx) begin
          m_state = S_LOCKED;
          m_conf  = conf;
        end else begin
          if (m_state == S_TRACK && int'(idx) == m_cand) m_run++;
          else begin m_cand = int'(idx); m_run = 1; end
          m_state = S_TRACK;
          if (m_run >= HOLD) begin
            m_valid = 1'b1; m_idx = idx; m_conf = conf; m_ascii = to_ascii(idx);
            m_run = 0; m_state = S_LOCKED;
          end
        end
      end else begin
        m_miss++;
        if (m_state == S_TRACK) begin m_state = S_IDLE; m_run = 0; end
        if (m_miss >= MISS) drop();
      end
    end
    m_change = (pv != m_valid) || (pi != m_idx);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic frame(input logic v, input logic [4:0] idx, input logic [7:0] conf);
    bus.cls_valid_i = v;
    bus.cls_idx_i   = idx;
    bus.cls_conf_i  = conf;
    model_step(v, idx, conf);
    @(posedge clk);
    #1;
    if (bus.pred_change_o) pulses++;
    check_eq("outs", dut_outs(), {15'd0, m_valid, m_idx, m_conf, m_change, 2'(m_state)});
`ifdef PRED_ASCII_EN
    check_eq("ascii", {24'd0, bus.pred_ascii_o}, {24'd0, m_ascii});
`endif
    @(negedge clk);
    bus.cls_valid_i = 1'b0;
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    check_eq("arst_outs", dut_outs(), 32'd0);
    bus.cls_valid_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic       v;
    logic [4:0] idx;
    logic [7:0] conf;

    bus.cls_valid_i = 1'b0;
    bus.cls_idx_i   = '0;
    bus.cls_conf_i  = '0;
    model_reset();
    #12;
    check_eq("rst_outs", dut_outs(), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Commit after four identical qualified frames
    pulses = 0;
    repeat (3) frame(1'b1, 5'd5, 8'd200);
    check_eq("t1_early_valid", {31'd0, bus.pred_valid_o}, 32'd0);
    frame(1'b1, 5'd5, 8'd200);
    check_eq("t1_valid", {31'd0, bus.pred_valid_o}, 32'd1);
    check_eq("t1_idx", {27'd0, bus.pred_idx_o}, 32'd5);
    check_eq("t1_conf", {24'd0, bus.pred_conf_o}, 32'd200);
    check_eq("t1_pulses", pulses, 32'd1);

    // Challenger interrupted by the held class, then wins on its 4th consecutive frame
    pulses = 0;
    frame(1'b1, 5'd9, 8'd200);
    frame(1'b1, 5'd9, 8'd200);
    frame(1'b1, 5'd5, 8'd200);
    repeat (3) frame(1'b1, 5'd9, 8'd200);
    check_eq("t2_hold_idx", {27'd0, bus.pred_idx_o}, 32'd5);
    check_eq("t2_hold_pulses", pulses, 32'd0);
    frame(1'b1, 5'd9, 8'd200);
    check_eq("t2_new_idx", {27'd0, bus.pred_idx_o}, 32'd9);
    check_eq("t2_pulses", pulses, 32'd1);

    // Low-confidence dropout clears after MISS frames; shorter dropouts are absorbed
    repeat (4) frame(1'b1, 5'd5, 8'd200);
    pulses = 0;
    repeat (3) frame(1'b1, 5'd5, 8'd100);
    check_eq("t3_drop_valid", {31'd0, bus.pred_valid_o}, 32'd0);
    check_eq("t3_drop_idx", {27'd0, bus.pred_idx_o}, 32'd5);
    check_eq("t3_drop_pulses", pulses, 32'd1);
    repeat (4) frame(1'b1, 5'd5, 8'd200);
    pulses = 0;
    repeat (2) frame(1'b1, 5'd5, 8'd100);
    frame(1'b1, 5'd5, 8'd200);
    check_eq("t3_keep_valid", {31'd0, bus.pred_valid_o}, 32'd1);
    check_eq("t3_keep_pulses", pulses, 32'd0);
    check_eq("t3_keep_state", {30'd0, bus.state_o}, 32'd2);

    // Out-of-range index is rejected even at full confidence
    async_reset();
    pulses = 0;
    repeat (MISS) frame(1'b1, 5'd30, 8'd255);
    check_eq("t4_state", {30'd0, bus.state_o}, 32'd0);
    check_eq("t4_valid", {31'd0, bus.pred_valid_o}, 32'd0);
    check_eq("t4_pulses", pulses, 32'd0);

    // Timeout with no strobes, then asynchronous reset while tracking
    repeat (4) frame(1'b1, 5'd12, 8'd180);
    pulses = 0;
    repeat (TMO - 1) frame(1'b0, 5'd12, 8'd180);
    check_eq("t5_pre_valid", {31'd0, bus.pred_valid_o}, 32'd1);
    frame(1'b0, 5'd3, 8'd0);
    check_eq("t5_valid", {31'd0, bus.pred_valid_o}, 32'd0);
    check_eq("t5_pulses", pulses, 32'd1);
    repeat (2) frame(1'b1, 5'd7, 8'd128);
    check_eq("t5_track", {30'd0, bus.state_o}, 32'd1);
    async_reset();

`ifdef PRED_ASCII_EN
    begin
      logic [4:0] a_idx [4];
      logic [7:0] a_exp [4];
      a_idx = '{5'd0, 5'd25, 5'd26, 5'd28};
      a_exp = '{8'h41, 8'h5A, 8'h7F, 8'h20};
      for (int k = 0; k < 4; k++) begin
        repeat (HOLD) frame(1'b1, a_idx[k], 8'd200);
        check_eq("t6_ascii", {24'd0, bus.pred_ascii_o}, {24'd0, a_exp[k]});
      end
    end
`endif

    // Randomized traffic biased towards a few competing classes
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        repeat (TMO + 2) frame(1'b0, 5'($urandom), 8'($urandom));
      end else begin
        v = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 9))
          0, 1, 2, 3: idx = 5'd5;
          4, 5, 6:    idx = 5'd9;
          7:          idx = 5'($urandom_range(0, 28));
          8:          idx = 5'($urandom_range(29, 31));
          default:    idx = 5'd28;
        endcase
        case ($urandom_range(0, 5))
          0:       conf = 8'($urandom_range(0, 127));
          1:       conf = 8'($urandom_range(127, 128));
          default: conf = 8'($urandom_range(129, 255));
        endcase
        frame(v, idx, conf);
      end
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
